// File: rtl/flash_cache_pkg.sv
// Shared types, default sizing and width helpers for the flash read cache.
package flash_cache_pkg;

    localparam int unsigned LINES_DEFAULT     = 32;
    localparam int unsigned ADDR_BITS_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Line index width: one word per line, so the index sits just above the byte offset.
    function automatic int unsigned index_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag covers every flash address bit above the index and byte offset.
    function automatic int unsigned tag_bits(input int unsigned addr_bits, input int unsigned lines);
        return addr_bits - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/flash_cache_if.sv
// CPU-side and flash-controller-side signals of the flash cache in one bundle.
// The cache itself connects through the slave modport; the environment uses master.
interface flash_cache_if;

    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        flush_in;

    logic [31:0] flash_address_out;
    logic        flash_sel_out;
    logic        flash_read_out;
    logic [31:0] flash_read_value_in;
    logic        flash_ready_in;

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in, flush_in,
        input  flash_read_value_in, flash_ready_in,
        output read_value_out, ready_out,
        output flash_address_out, flash_sel_out, flash_read_out
    );

    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in, flush_in,
        output flash_read_value_in, flash_ready_in,
        input  read_value_out, ready_out,
        input  flash_address_out, flash_sel_out, flash_read_out
    );

endinterface

// File: rtl/flash_cache_ram.sv
// Tag + data storage for the direct-mapped cache: synchronous write, asynchronous read.
// Contents are not reset; the valid flops in the parent gate every use.
module flash_cache_ram
    import flash_cache_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEFAULT,
    parameter int unsigned IDX_W = index_bits(LINES_DEFAULT),
    parameter int unsigned TAG_W = tag_bits(ADDR_BITS_DEFAULT, LINES_DEFAULT)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [TAG_W-1:0] rtag_o,
    output logic [31:0]      rdata_o
);

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Line write at the end of a flash fill.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[waddr_i]  <= wtag_i;
            data_mem[waddr_i] <= wdata_i;
        end
    end

    assign rtag_o  = tag_mem[raddr_i];
    assign rdata_o = data_mem[raddr_i];

endmodule

// File: rtl/flash_cache.sv
// Direct-mapped, one-word-per-line read cache in front of a flash controller.
// Reads hit in one cycle or fill from flash; writes are acknowledged and dropped.
module flash_cache
    import flash_cache_pkg::*;
#(
    parameter int unsigned LINES     = LINES_DEFAULT,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    flash_cache_if.slave bus
);

    localparam int unsigned IDX_W = index_bits(LINES);
    localparam int unsigned TAG_W = tag_bits(ADDR_BITS, LINES);

    state_t           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      faddr_q, faddr_d;
    logic [31:0]      data_q, data_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic [31:0]      fill_addr;
    logic             line_we;
    logic             hit;
    logic             unused_bits;

    assign req_idx = bus.address_in[IDX_W+1:2];
    assign req_tag = bus.address_in[ADDR_BITS-1:IDX_W+2];
    assign hit     = valid_q[req_idx] && (line_tag == req_tag);
    assign line_we = (state_q == ST_FILL) && bus.flash_ready_in;

    // Write data/mask, the byte offset and address bits above ADDR_BITS carry no meaning here.
    assign unused_bits = ^{bus.write_mask_in, bus.write_value_in, bus.address_in};

    // Word-aligned flash address with bits above ADDR_BITS forced to zero.
    always_comb begin
        fill_addr                  = '0;
        fill_addr[ADDR_BITS-1:2]   = bus.address_in[ADDR_BITS-1:2];
    end

    flash_cache_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (line_we),
        .waddr_i (idx_q),
        .wtag_i  (tag_q),
        .wdata_i (bus.flash_read_value_in),
        .raddr_i (req_idx),
        .rtag_o  (line_tag),
        .rdata_o (line_data)
    );

    // Next-state logic: lookup in IDLE, wait for flash in FILL, single response cycle.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        faddr_d = faddr_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.sel_in) begin
                    if (!bus.read_in) begin
                        data_d  = '0;
                        state_d = ST_RESPOND;
                    end else if (hit && !bus.flush_in) begin
                        data_d  = line_data;
                        state_d = ST_RESPOND;
                    end else begin
                        idx_d   = req_idx;
                        tag_d   = req_tag;
                        faddr_d = fill_addr;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (bus.flash_ready_in) begin
                    valid_d[idx_q] = 1'b1;
                    data_d         = bus.flash_read_value_in;
                    state_d        = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over a same-cycle fill, so that line lands invalid.
        if (bus.flush_in) begin
            valid_d = '0;
        end
    end

    // State, valid bits and latched request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            faddr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            faddr_q <= faddr_d;
            data_q  <= data_d;
        end
    end

    assign bus.ready_out         = (state_q == ST_RESPOND) && bus.sel_in;
    assign bus.read_value_out    = bus.ready_out ? data_q : '0;
    assign bus.flash_sel_out     = (state_q == ST_FILL);
    assign bus.flash_read_out    = (state_q == ST_FILL);
    assign bus.flash_address_out = faddr_q;

endmodule
